// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative radix-2 mul/div/madd/msub; in: clk,rst,start_i,op_i,opdata1_i,opdata2_i,hilo_i,annul_i; out: result_o,ready_o,stallreq_o
module ex_muldiv #(
  parameter int DATA_W = 32,
  parameter int CNT_W = $clog2(DATA_W + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic [2*DATA_W-1:0]   hilo_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);
  localparam logic [1:0] IDLE = 2'd0, BYZERO = 2'd1, RUN = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic [2:0] op, op_in;
  logic sa, sb, sgn_in, div_in, div;
  logic [DATA_W-1:0] m, mag1, mag2, q, r;
  logic [2*DATA_W-1:0] p, hilo, prod, fin;
  logic [DATA_W:0] sum, rem_ext, diff;
  always_comb begin
    op_in = (op_i[2] & op_i[1]) ? 3'b000 : op_i;
    sgn_in = op_in[0] | op_in[2];
    div_in = op_in[2:1] == 2'b01;
    mag1 = (sgn_in & opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    mag2 = (sgn_in & opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    div = op[2:1] == 2'b01;
    sum = {1'b0, p[2*DATA_W-1:DATA_W]} + (p[0] ? {1'b0, m} : '0);
    rem_ext = {p[2*DATA_W-1:DATA_W], p[DATA_W-1]};
    diff = rem_ext - {1'b0, m};
    prod = (sa ^ sb) ? -p : p;
    q = (sa ^ sb) ? -p[DATA_W-1:0] : p[DATA_W-1:0];
    r = sa ? -p[2*DATA_W-1:DATA_W] : p[2*DATA_W-1:DATA_W];
    fin = div ? {r, q} : (op == 3'b100) ? hilo + prod : (op == 3'b101) ? hilo - prod : prod;
  end
  assign stallreq_o = start_i & ~annul_i & (state != DONE) & ~rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      op <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      m <= '0;
      p <= '0;
      hilo <= '0;
      ready_o <= 1'b0;
      result_o <= '0;
    end else if (state == IDLE) begin
      if (start_i & ~annul_i) begin
        op <= op_in;
        sa <= sgn_in & opdata1_i[DATA_W-1];
        sb <= sgn_in & opdata2_i[DATA_W-1];
        m <= div_in ? mag2 : mag1;
        p <= {{DATA_W{1'b0}}, div_in ? mag1 : mag2};
        hilo <= hilo_i;
        cnt <= '0;
        state <= (div_in && opdata2_i == '0) ? BYZERO : RUN;
      end
    end else if (state == DONE) begin
      if (!start_i) begin
        state <= IDLE;
        ready_o <= 1'b0;
        result_o <= '0;
      end
    end else if (annul_i) begin
      state <= IDLE;
    end else if (state == BYZERO) begin
      cnt <= cnt + 1'b1;
      if (cnt[0]) begin
        state <= DONE;
        ready_o <= 1'b1;
        result_o <= '0;
      end
    end else if (cnt == CNT_W'(DATA_W)) begin
      state <= DONE;
      ready_o <= 1'b1;
      result_o <= fin;
    end else begin
      cnt <= cnt + 1'b1;
      p <= div ? (diff[DATA_W] ? {rem_ext[DATA_W-1:0], p[DATA_W-2:0], 1'b0}
                               : {diff[DATA_W-1:0], p[DATA_W-2:0], 1'b1})
               : {sum, p[DATA_W-1:1]};
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: randomized and directed checks of ex_muldiv against an arithmetic reference model
module tb_ex_muldiv;
  logic clk = 1'b0;
  logic rst, start_i, annul_i, ready_o, stallreq_o;
  logic [2:0] op_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] hilo_i, result_o;
  int total = 0, bad = 0;
  ex_muldiv #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i), .hilo_i(hilo_i), .annul_i(annul_i), .result_o(result_o),
    .ready_o(ready_o), .stallreq_o(stallreq_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] h);
    longint x, y;
    logic [63:0] sp, up, q, r;
    x = longint'($signed(a));
    y = longint'($signed(b));
    sp = x * y;
    up = {32'b0, a} * {32'b0, b};
    if (op == 3'd2) return (b == 0) ? 64'd0 : {a % b, a / b};
    if (op == 3'd3) begin
      if (b == 0) return 64'd0;
      q = x / y;
      r = x % y;
      return {r[31:0], q[31:0]};
    end
    if (op == 3'd1) return sp;
    if (op == 3'd4) return h + sp;
    if (op == 3'd5) return h - sp;
    return up;
  endfunction
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] h);
    logic [63:0] exp;
    int k, explat;
    logic stall_ok;
    exp = model(op, a, b, h);
    explat = ((op == 3'd2 || op == 3'd3) && b == 0) ? 2 : 33;
    start_i = 1'b1;
    annul_i = 1'b0;
    op_i = op;
    opdata1_i = a;
    opdata2_i = b;
    hilo_i = h;
    #1 stall_ok = stallreq_o;
    @(posedge clk);
    k = 0;
    @(negedge clk);
    op_i = 3'($urandom);
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    hilo_i = {$urandom, $urandom};
    while (!ready_o && k < 100) begin
      if (!stallreq_o) stall_ok = 1'b0;
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    check({tag, "_lat"}, 64'(k), 64'(explat));
    check({tag, "_res"}, result_o, exp);
    check({tag, "_stall"}, {63'd0, stall_ok & ~stallreq_o}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_hold"}, {ready_o, result_o[62:0]}, {1'b1, exp[62:0]});
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_clr"}, {63'd0, ready_o} | result_o, 64'd0);
  endtask
  task automatic abort_test(input string tag, input bit use_rst);
    logic seen;
    seen = 1'b0;
    start_i = 1'b1;
    annul_i = 1'b0;
    op_i = 3'd2;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    hilo_i = 64'd0;
    @(posedge clk);
    for (int i = 1; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      seen |= ready_o;
    end
    if (use_rst) begin
      rst = 1'b1;
      #1 check({tag, "_rst_stall"}, {63'd0, stallreq_o}, 64'd0);
    end else begin
      annul_i = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    seen |= ready_o;
    rst = 1'b0;
    annul_i = 1'b0;
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    seen |= ready_o;
    check({tag, "_noready"}, {63'd0, seen}, 64'd0);
    run_op({tag, "_restart"}, 3'd2, 32'd100, 32'd7, 64'd0);
  endtask
  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    int sel;
    rst = 1'b1;
    start_i = 1'b1;
    annul_i = 1'b0;
    op_i = 3'd0;
    opdata1_i = 32'd3;
    opdata2_i = 32'd4;
    hilo_i = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall", {63'd0, stallreq_o}, 64'd0);
    check("reset_out", {63'd0, ready_o} | result_o, 64'd0);
    rst = 1'b0;
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_out", {63'd0, ready_o} | result_o, 64'd0);
    run_op("divu_100_7", 3'd2, 32'd100, 32'd7, 64'd0);
    check("divu_100_7_ref", model(3'd2, 32'd100, 32'd7, 64'd0), 64'h00000002_0000000E);
    run_op("div_m7_2", 3'd3, 32'hFFFFFFF9, 32'd2, 64'd0);
    run_op("div_minneg", 3'd3, 32'h80000000, 32'hFFFFFFFF, 64'd0);
    run_op("div_by0", 3'd3, 32'd5, 32'd0, 64'h1234);
    run_op("divu_by0", 3'd2, 32'd9, 32'd0, 64'd0);
    run_op("mult_m3_5", 3'd1, 32'hFFFFFFFD, 32'd5, 64'd0);
    run_op("madd", 3'd4, 32'd2, 32'd3, 64'd1);
    run_op("msub", 3'd5, 32'd1, 32'd1, 64'd0);
    run_op("op7_multu", 3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0);
    annul_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle_annul", {63'd0, stallreq_o}, 64'd0);
    annul_i = 1'b0;
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    abort_test("annul", 1'b0);
    abort_test("rst", 1'b1);
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      a = (sel == 3) ? 32'h80000000 : $urandom;
      b = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFFFFFF : (sel == 2) ? 32'($urandom_range(1, 20)) : $urandom;
      run_op($sformatf("rnd%0d_op%0d", n, op), op, a, b, {$urandom, $urandom});
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter DATA_W, default 32, operand width; legal range 4..64.
REQ-002 Parameter CNT_W, default $clog2(DATA_W+1), iteration counter width; derived, not overridden.
REQ-003 clk  in  1  Single clock; all state updates on rising edge.
REQ-004 rst  in  1  Reset, synchronous and active-high.
REQ-005 start_i  in  1  Operation request; held high by the EX stage until ready_o is seen.
REQ-006 op_i  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MADD, 101 MSUB; 110/111 are executed as MULTU.
REQ-007 opdata1_i  in  DATA_W  Multiplicand or dividend.
REQ-008 opdata2_i  in  DATA_W  Multiplier or divisor.
REQ-009 hilo_i  in  2*DATA_W  Current {HI,LO}, already forwarded; accumulator for MADD/MSUB.
REQ-010 annul_i  in  1  Cancel the in-flight operation (branch squash or flush).
REQ-011 result_o  out  2*DATA_W  {HI,LO} result.
REQ-012 ready_o  out  1  result_o valid.
REQ-013 stallreq_o  out  1  Pipeline stall request.

Function
REQ-014 The FSM SHALL have four states, IDLE, BYZERO, RUN and DONE, plus a CNT_W-bit iteration counter.
REQ-015 In IDLE, start_i=1 and annul_i=0 SHALL capture op_i, opdata1_i, opdata2_i and hilo_i; inputs SHALL be ignored from then until IDLE is re-entered.
REQ-016 Capture with op DIV/DIVU and opdata2_i=0 SHALL go to BYZERO; every other capture SHALL go to RUN with counter=0.
REQ-017 BYZERO SHALL go to DONE on the next cycle with result {0,0}.
REQ-018 RUN SHALL do one radix-2 step per cycle (shift-add multiply, restoring divide) on operand magnitudes, and SHALL go to DONE when counter reaches DATA_W.
REQ-019 Latency: the start edge is T; the result is valid in DONE at T+DATA_W+1 (T+2 for divide-by-zero).
REQ-020 Signed ops (MULT, DIV, MADD, MSUB) SHALL take two's-complement magnitudes at capture and apply sign correction on entry to DONE.
REQ-021 Product sign SHALL be the XOR of the operand signs.
REQ-022 Quotient sign SHALL be the XOR of the operand signs; remainder sign SHALL equal the dividend sign.
REQ-023 Divide result SHALL be {remainder, quotient}; multiply result SHALL be the full 2*DATA_W product.
REQ-024 MADD result SHALL be hilo + signed product, MSUB result SHALL be hilo - signed product, using the captured hilo; both SHALL wrap modulo 2^(2*DATA_W).
REQ-025 DIV of most-negative by -1 SHALL give quotient most-negative (wrap) and remainder 0, with no exception.
REQ-026 In DONE, ready_o=1 and result_o SHALL be held stable while start_i=1.
REQ-027 DONE with start_i=0 SHALL go to IDLE next cycle, with ready_o=0 and result_o=0.
REQ-028 A back-to-back operation SHALL require start_i low for at least one cycle.
REQ-029 annul_i=1 in BYZERO or RUN SHALL go to IDLE next cycle without asserting ready_o; annul_i is ignored in DONE.
REQ-030 annul_i=1 in IDLE SHALL block capture.
REQ-031 stallreq_o SHALL equal start_i & ~annul_i & (state != DONE), combinationally.
REQ-032 ready_o SHALL be registered, and result_o SHALL be 0 whenever ready_o=0.

Reset
REQ-033 rst=1 at a clock edge SHALL force IDLE, counter=0, ready_o=0, result_o=0 and all operand registers to 0, in any state including mid-RUN.
REQ-034 stallreq_o SHALL be 0 while rst=1.
REQ-035 The first capture SHALL occur no earlier than the first edge after rst falls.

Verification (DATA_W=32)
REQ-036 DIVU, 100/7, start at T -> ready_o at T+33; result_o {HI=0x00000002, LO=0x0000000E}; stallreq_o high T..T+32.
REQ-037 DIV, -7/2 -> {HI=0xFFFFFFFF, LO=0xFFFFFFFD}; separately, DIV 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}.
REQ-038 DIV, 5/0 -> BYZERO, ready_o at T+2, result_o all zero.
REQ-039 MULT, -3*5 -> 0xFFFFFFFF_FFFFFFF1.
REQ-040 MADD, hilo_i=1, 2*3 -> 0x00000000_00000007.
REQ-041 MSUB, hilo_i=0, 1*1 -> 0xFFFFFFFF_FFFFFFFF.
REQ-042 annul_i pulsed at T+10 of a DIVU, and separately rst at T+10 -> IDLE; ready_o never rises; a new start at T+12 completes normally at T+45.
